// File: rtl/ecc_lane_pkg.sv
// rtl/ecc_lane_pkg.sv - shared types and GF(2^m) helpers for the ECC lane array
package ecc_lane_pkg;

    localparam int MAX_SYM_W = 16;
    localparam logic [8:0] DEFAULT_GF_POLY = 9'h11D;

    typedef enum logic [1:0] {
        ST_DATA,
        ST_PAR0,
        ST_PAR1
    } state_e;

    // Multiply by x in GF(2^sym_w); poly carries only the low sym_w bits of the generator.
    function automatic logic [MAX_SYM_W-1:0] mulx(
        input logic [MAX_SYM_W-1:0] a,
        input int                   sym_w,
        input logic [MAX_SYM_W-1:0] poly
    );
        logic [MAX_SYM_W-1:0] mask;
        logic [MAX_SYM_W-1:0] r;
        logic                 msb;
        msb = 1'b0;
        for (int i = 0; i < MAX_SYM_W; i++) begin
            mask[i] = (i < sym_w);
            if (i == sym_w - 1) begin
                msb = a[i];
            end
        end
        r = {a[MAX_SYM_W-2:0], 1'b0} & mask;
        if (msb) begin
            r = r ^ (poly & mask);
        end
        return r;
    endfunction

endpackage

// File: rtl/ecc_lane_acc.sv
// rtl/ecc_lane_acc.sv - one lane's XOR parity (S0) and Horner checksum (S1) accumulators
module ecc_lane_acc
    import ecc_lane_pkg::*;
#(
    parameter int               SYM_W   = 8,
    parameter logic [SYM_W:0]   GF_POLY = (SYM_W+1)'(DEFAULT_GF_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [SYM_W-1:0] d,
    output logic [SYM_W-1:0] s0,
    output logic [SYM_W-1:0] s1
);

    logic [SYM_W-1:0] s0_q, s0_d;
    logic [SYM_W-1:0] s1_q, s1_d;
    logic [SYM_W-1:0] s1_x;

    assign s1_x = SYM_W'(mulx(MAX_SYM_W'(s1_q), SYM_W, MAX_SYM_W'(GF_POLY[SYM_W-1:0])));

    always_comb begin
        s0_d = s0_q;
        s1_d = s1_q;
        if (clr) begin
            s0_d = '0;
            s1_d = '0;
        end else if (en) begin
            s0_d = s0_q ^ d;
            s1_d = s1_x ^ d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q <= '0;
            s1_q <= '0;
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
        end
    end

    assign s0 = s0_q;
    assign s1 = s1_q;

endmodule

// File: rtl/ecc_lane_array.sv
// rtl/ecc_lane_array.sv - multi-lane systematic encoder: K data beats then S0 and S1 check beats
module ecc_lane_array
    import ecc_lane_pkg::*;
#(
    parameter int             NUM_LANES = 16,
    parameter int             SYM_W     = 8,
    parameter logic [SYM_W:0] GF_POLY   = (SYM_W+1)'(DEFAULT_GF_POLY),
    parameter int             K_SYMS    = 252
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_LANES*SYM_W-1:0] s_tdata,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    output logic [NUM_LANES*SYM_W-1:0] m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       m_tlast,
    output logic                       frame_done
);

    localparam int DW = NUM_LANES * SYM_W;

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [DW-1:0]   m_tdata_q, m_tdata_d;
    logic            m_tvalid_q, m_tvalid_d;
    logic            m_tlast_q, m_tlast_d;
    logic            frame_done_q, frame_done_d;
    logic [DW-1:0]   s0_all, s1_all;
    logic            slot_free, accept, acc_clr;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        ecc_lane_acc #(
            .SYM_W   (SYM_W),
            .GF_POLY (GF_POLY)
        ) u_acc (
            .clk (clk),
            .rst (rst),
            .en  (accept),
            .clr (acc_clr),
            .d   (s_tdata[g*SYM_W +: SYM_W]),
            .s0  (s0_all[g*SYM_W +: SYM_W]),
            .s1  (s1_all[g*SYM_W +: SYM_W])
        );
    end

    assign slot_free = !m_tvalid_q || m_tready;
    assign s_tready  = (state_q == ST_DATA) && slot_free;
    assign accept    = s_tvalid && s_tready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        m_tdata_d    = m_tdata_q;
        m_tvalid_d   = m_tvalid_q;
        m_tlast_d    = m_tlast_q;
        acc_clr      = 1'b0;
        frame_done_d = m_tvalid_q && m_tready && m_tlast_q;
        // Slot drains unless something new is loaded below.
        if (slot_free) begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
        end
        case (state_q)
            ST_DATA: begin
                if (accept) begin
                    m_tdata_d  = s_tdata;
                    m_tvalid_d = 1'b1;
                    if (cnt_q == 16'(K_SYMS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_PAR0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_PAR0: begin
                if (slot_free) begin
                    m_tdata_d  = s0_all;
                    m_tvalid_d = 1'b1;
                    state_d    = ST_PAR1;
                end
            end
            ST_PAR1: begin
                if (slot_free) begin
                    m_tdata_d  = s1_all;
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = 1'b1;
                    acc_clr    = 1'b1;
                    state_d    = ST_DATA;
                end
            end
            default: state_d = ST_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_DATA;
            cnt_q        <= '0;
            m_tdata_q    <= '0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign m_tdata    = m_tdata_q;
    assign m_tvalid   = m_tvalid_q;
    assign m_tlast    = m_tlast_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ecc_lane_array.sv
// tb/tb_ecc_lane_array.sv - bench for ecc_lane_array: small fixed vectors plus a random wide-frame model
module tb_ecc_lane_array;

    localparam int NLA = 2;
    localparam int KA  = 4;
    localparam int NLB = 16;
    localparam int KB  = 252;
    localparam logic [8:0] GFP = 9'h11D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [NLA*8-1:0] s_tdata_a = '0, m_tdata_a;
    logic s_tvalid_a = 1'b0, s_tready_a, m_tvalid_a, m_tready_a = 1'b1, m_tlast_a, frame_done_a;
    logic [NLB*8-1:0] s_tdata_b = '0, m_tdata_b;
    logic s_tvalid_b = 1'b0, s_tready_b, m_tvalid_b, m_tready_b = 1'b1, m_tlast_b, frame_done_b;

    ecc_lane_array #(.NUM_LANES(NLA), .SYM_W(8), .GF_POLY(GFP), .K_SYMS(KA)) dut_a (
        .clk(clk), .rst(rst), .s_tdata(s_tdata_a), .s_tvalid(s_tvalid_a), .s_tready(s_tready_a),
        .m_tdata(m_tdata_a), .m_tvalid(m_tvalid_a), .m_tready(m_tready_a), .m_tlast(m_tlast_a),
        .frame_done(frame_done_a));

    ecc_lane_array #(.NUM_LANES(NLB), .SYM_W(8), .GF_POLY(GFP), .K_SYMS(KB)) dut_b (
        .clk(clk), .rst(rst), .s_tdata(s_tdata_b), .s_tvalid(s_tvalid_b), .s_tready(s_tready_b),
        .m_tdata(m_tdata_b), .m_tvalid(m_tvalid_b), .m_tready(m_tready_b), .m_tlast(m_tlast_b),
        .frame_done(frame_done_b));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Carry-less product followed by polynomial long division.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        logic [15:0] g;
        p = '0;
        g = {7'd0, GFP};
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'd0, a} << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (g << (i - 8));
        return p[7:0];
    endfunction

    typedef struct {
        logic [15:0] in_d;
        logic [15:0] exp_d;
        logic        exp_last;
    } vec_t;
    vec_t tbl[6];

    logic [15:0] got_d[$];
    logic        got_l[$];
    int          got_t[$];
    int          cyc_a = 0;
    int          mode_a = 0;
    int          in_cnt_a = 0;
    logic        full_a = 1'b0, fd_pend_a = 1'b0, prev_stall_a = 1'b0;
    logic [15:0] prev_d_a = '0;
    logic        prev_l_a = 1'b0;

    // Ready pattern for the small DUT: constant 1 or repeating 1,0,0.
    always @(posedge clk) begin
        #1;
        if (mode_a == 1) m_tready_a = ((cyc_a % 3) == 0);
        else             m_tready_a = 1'b1;
    end

    always @(negedge clk) begin
        cyc_a++;
        if (rst) begin
            in_cnt_a = 0; full_a = 1'b0; fd_pend_a = 1'b0; prev_stall_a = 1'b0;
        end else begin
            if (prev_stall_a) begin
                check("a_hold_data", 128'(m_tdata_a), 128'(prev_d_a));
                check("a_hold_valid", 128'(m_tvalid_a), 128'(1'b1));
                check("a_hold_last", 128'(m_tlast_a), 128'(prev_l_a));
            end
            if (full_a && !(m_tvalid_a && m_tready_a && m_tlast_a))
                check("a_s_tready_during_checks", 128'(s_tready_a), 128'(1'b0));
            if (fd_pend_a || frame_done_a)
                check("a_frame_done", 128'(frame_done_a), 128'(fd_pend_a));
            fd_pend_a = m_tvalid_a && m_tready_a && m_tlast_a;
            if (m_tvalid_a && m_tready_a) begin
                got_d.push_back(m_tdata_a);
                got_l.push_back(m_tlast_a);
                got_t.push_back(cyc_a);
                if (m_tlast_a) full_a = 1'b0;
            end
            if (s_tvalid_a && s_tready_a) begin
                in_cnt_a++;
                if (in_cnt_a == KA) begin
                    in_cnt_a = 0;
                    full_a = 1'b1;
                end
            end
            prev_stall_a = m_tvalid_a && !m_tready_a;
            prev_d_a = m_tdata_a;
            prev_l_a = m_tlast_a;
        end
    end

    task automatic send_a(input logic [15:0] d, input int gap);
        logic acc;
        int   n;
        s_tvalid_a = 1'b1;
        s_tdata_a  = d;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = s_tready_a;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("a_input_accept_timeout", 128'(0), 128'(1));
        s_tvalid_a = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_beats_a(input int n);
        int c;
        c = 0;
        while (got_d.size() < n && c < 200) begin
            @(posedge clk);
            c++;
        end
        if (got_d.size() < n) check("a_output_timeout", 128'(got_d.size()), 128'(n));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        got_d.delete();
        got_l.delete();
        got_t.delete();
    endtask

    task automatic compare_frame_a(input string tag, input int base);
        for (int i = 0; i < 6; i++) begin
            if (base + i < got_d.size()) begin
                check({tag, "_data"}, 128'(got_d[base+i]), 128'(tbl[i].exp_d));
                check({tag, "_last"}, 128'(got_l[base+i]), 128'(tbl[i].exp_last));
            end else begin
                check({tag, "_missing_beat"}, 128'(got_d.size()), 128'(base + 6));
            end
        end
    endtask

    // Wide DUT: random data, random gaps and random backpressure.
    logic [NLB*8-1:0] exp_q[$];
    logic             exp_lq[$];
    logic [7:0]       fr[NLB][KB];
    logic [7:0]       pw[KB];
    int               beat_in_frame_b = 0;
    logic             run_b = 1'b0;

    always @(posedge clk) begin
        #1;
        if (run_b) m_tready_b = ($urandom_range(0, 3) != 0);
        else       m_tready_b = 1'b1;
    end

    always @(negedge clk) begin
        if (!rst && m_tvalid_b && m_tready_b) begin
            beat_in_frame_b++;
            if (exp_q.size() == 0) begin
                check("b_unexpected_beat", 128'(m_tdata_b), 128'(0));
            end else begin
                check("b_data", m_tdata_b, exp_q.pop_front());
                check("b_last", 128'(m_tlast_b), 128'(exp_lq.pop_front()));
            end
            if (m_tlast_b) begin
                check("b_beats_per_frame", 128'(beat_in_frame_b), 128'(KB + 2));
                beat_in_frame_b = 0;
            end
        end
    end

    task automatic send_b(input logic [NLB*8-1:0] d);
        logic acc;
        int   n;
        s_tvalid_b = 1'b1;
        s_tdata_b  = d;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = s_tready_b;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("b_input_accept_timeout", 128'(0), 128'(1));
        s_tvalid_b = 1'b0;
    endtask

    task automatic run_frame_b();
        logic [NLB*8-1:0] d, w0, w1;
        logic [7:0] s0, s1;
        for (int j = 0; j < KB; j++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            for (int l = 0; l < NLB; l++) fr[l][j] = d[l*8 +: 8];
            exp_q.push_back(d);
            exp_lq.push_back(1'b0);
            send_b(d);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        for (int l = 0; l < NLB; l++) begin
            s0 = '0;
            s1 = '0;
            for (int j = 0; j < KB; j++) begin
                s0 = s0 ^ fr[l][j];
                s1 = s1 ^ gf_mul(fr[l][j], pw[KB-1-j]);
            end
            w0[l*8 +: 8] = s0;
            w1[l*8 +: 8] = s1;
        end
        exp_q.push_back(w0);
        exp_lq.push_back(1'b0);
        exp_q.push_back(w1);
        exp_lq.push_back(1'b1);
    endtask

    initial begin
        tbl[0] = '{16'h8001, 16'h8001, 1'b0};
        tbl[1] = '{16'h8002, 16'h8002, 1'b0};
        tbl[2] = '{16'h8003, 16'h8003, 1'b0};
        tbl[3] = '{16'h8004, 16'h8004, 1'b0};
        tbl[4] = '{16'h0000, 16'h0004, 1'b0};
        tbl[5] = '{16'h0000, 16'hD302, 1'b1};
        pw[0] = 8'h01;
        for (int e = 1; e < KB; e++) pw[e] = gf_mul(pw[e-1], 8'h02);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_m_tvalid", 128'(m_tvalid_a), 128'(0));
        check("reset_m_tdata", 128'(m_tdata_a), 128'(0));
        check("reset_m_tlast", 128'(m_tlast_a), 128'(0));
        check("reset_frame_done", 128'(frame_done_a), 128'(0));
        check("reset_s_tready", 128'(s_tready_a), 128'(1));
        @(posedge clk);
        #1;

        // Basic frame
        clear_a();
        for (int i = 0; i < KA; i++) send_a(tbl[i].in_d, 0);
        wait_beats_a(6);
        compare_frame_a("s1", 0);
        check("s1_beat_count", 128'(got_d.size()), 128'(6));

        // Output backpressure 1,0,0
        clear_a();
        mode_a = 1;
        for (int i = 0; i < KA; i++) send_a(tbl[i].in_d, 0);
        wait_beats_a(6);
        mode_a = 0;
        repeat (3) @(posedge clk);
        #1;
        compare_frame_a("s2", 0);
        check("s2_beat_count", 128'(got_d.size()), 128'(6));

        // Two back-to-back frames
        clear_a();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < KA; i++) send_a(tbl[i].in_d, 0);
        wait_beats_a(12);
        compare_frame_a("s3f0", 0);
        compare_frame_a("s3f1", 6);
        for (int i = 0; i < 11; i++)
            if (i + 1 < got_t.size()) check("s3_no_bubble", 128'(got_t[i+1] - got_t[i]), 128'(1));

        // Reset in mid-frame discards the partial frame
        for (int i = 0; i < 2; i++) send_a(tbl[i].in_d, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("s4_m_tvalid_after_reset", 128'(m_tvalid_a), 128'(0));
        @(posedge clk);
        #1;
        clear_a();
        for (int i = 0; i < KA; i++) send_a(tbl[i].in_d, 0);
        wait_beats_a(6);
        compare_frame_a("s4", 0);
        check("s4_beat_count", 128'(got_d.size()), 128'(6));

        // Input gaps
        clear_a();
        for (int i = 0; i < KA; i++) send_a(tbl[i].in_d, 1);
        wait_beats_a(6);
        compare_frame_a("s5", 0);
        for (int i = 0; i < 3; i++)
            if (i + 1 < got_t.size()) check("s5_gap_spacing", 128'(got_t[i+1] - got_t[i]), 128'(2));

        // Wide random frames
        run_b = 1'b1;
        for (int f = 0; f < 2; f++) run_frame_b();
        begin
            int c;
            c = 0;
            while (exp_q.size() != 0 && c < 3000) begin
                @(posedge clk);
                c++;
            end
            check("b_drain", 128'(exp_q.size()), 128'(0));
        end
        run_b = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
